tournament_update_queue: RTL and testbench
==========================================

// Module: tournament_update_queue
// PURPOSE
//  In-flight branch tracker that sits directly upstream of the tournament predictor's update port.
//  - Allocates one entry per predicted branch at fetch.
//  - Accepts out-of-order resolution from execute.
//  - Retires entries strictly in order, driving the predictor write port (w_v/idx_w/correct/taken).
//  - On a mispredict, squashes younger entries and emits a GHR restore value.
// PARAMETERS
//  bht_idx_width_p  10  width of predictor table index (idx_w)
//  ghist_width_p    12  global history width, matches GHR
//  depth_p           8  entries; power of 2, >=2
//  tag_width_p      $clog2(depth_p)  derived, do not override
// PORTS
//  clk_i               in   1               rising-edge clock
//  reset_n_i           in   1               asynchronous, active-low reset
//  pred_v_i            in   1               allocate request (a prediction was made)
//  pred_ready_o        out  1               queue can accept; = !full
//  pred_idx_i          in   bht_idx_width_p index used for the prediction
//  pred_ghist_i        in   ghist_width_p   GHR snapshot at prediction time
//  pred_taken_i        in   1               predicted direction
//  pred_choice_i       in   1               component chosen: 1=global, 0=local
//  pred_tag_o          out  tag_width_p     tag of the entry allocated this cycle (= tail)
//  res_v_i             in   1               branch resolved
//  res_tag_i           in   tag_width_p     tag being resolved
//  res_taken_i         in   1               actual direction
//  w_v_o               out  1               update valid to predictor
//  w_ready_i           in   1               predictor accepts update
//  idx_w_o             out  bht_idx_width_p index to update
//  correct_o           out  1               prediction matched actual
//  taken_o             out  1               actual direction
//  choice_o            out  1               component that was used
//  ghist_restore_v_o   out  1               one-cycle pulse on mispredict
//  ghist_restore_o     out  ghist_width_p   {snap[ghist_width_p-2:0], res_taken}
//  count_o             out  tag_width_p+1   occupied entries
// BEHAVIOUR
//  Reset (async, reset_n_i=0):
//  - All entries go to IDLE; head/tail pointers go to 0.
//  - All outputs are 0, except pred_ready_o=1.
//  Pointers and occupancy:
//  - Head/tail carry an extra wrap bit.
//  - empty when head==tail.
//  - full when the index bits are equal and the wrap bits differ.
//  Entry states and transitions:
//  - IDLE -> PEND on allocate.
//  - PEND -> DONE on matching resolve.
//  - DONE -> IDLE on retire or squash.
//  - PEND -> IDLE on squash.
//  Allocate: when pred_v_i && pred_ready_o, write the entry at tail and increment tail.
//  - pred_tag_o is combinational (= tail index).
//  Resolve:
//  - Applies only if entry[res_tag_i] is PEND. Otherwise it is ignored (no state change, no pulse).
//  - Stores res_taken_i and correct = (res_taken_i == pred_taken). State -> DONE at the edge.
//  Mispredict (resolve with correct=0):
//  - At the same edge, tail <= res_tag_i+1 (wrap bit adjusted). All entries younger than it become IDLE.
//  - Next cycle, ghist_restore_v_o=1 for exactly one cycle.
//  - An allocate in the same cycle is discarded: tail is not advanced by it.
//  Retire:
//  - w_v_o = (head entry is DONE), driven from registers only.
//  - The payload is the head entry's fields.
//  - On w_v_o && w_ready_i, the entry -> IDLE and head increments.
//  - w_v_o and the payload hold stable while w_ready_i=0.
//  Latency: resolve in cycle N -> earliest w_v_o in N+1. Back-to-back retires are allowed, one per cycle.
//  Simultaneous events:
//  - Allocate + retire when full: allocate is refused (pred_ready_o computed from start-of-cycle state).
//  - Resolve of the head + retire of the head in the same cycle cannot occur (head is PEND, not DONE).
//  - Squash + retire in the same cycle: retire proceeds; the squash never removes the head, which is older.
//  - Two resolves: not possible (single resolve port).
//  Wrap-around: tags are modulo depth_p; comparisons use pointer arithmetic, never raw tag magnitude.
//  count_o = tail - head, modulo 2*depth_p.
// STRUCTURE
//  - Package tournament_pkg:
//    - typedef enum logic [1:0] {IDLE, PEND, DONE} tuq_state_e;
//    - typedef struct packed tuq_entry_s {idx, ghist, pred_taken, choice, taken, correct}.
//  - Sub-module tuq_ptr: pointer/wrap-bit counter with inc and load. Instantiated twice, for head and tail.
//  - The entry array is flops (no SRAM), because entries need random-access resolve writes.
// TESTING
//  1. Reset mid-operation: fill 3 entries, drop reset_n_i -> count_o=0, w_v_o=0, pred_ready_o=1 in the same cycle.
//  2. Fill: 8 allocates with idx 0..7 -> pred_tag_o 0..7, pred_ready_o=0 after the 8th.
//     - A 9th pred_v_i is ignored; count_o=8.
//  3. Out-of-order resolve: tags 2,1,0, all correct.
//     - w_v_o stays low until tag 0 resolves, then retires idx 0,1,2 on consecutive cycles.
//  4. Mispredict: 6 allocated, resolve tag 3 with pred_taken=1, res_taken=0, ghist snap 12'hABC.
//     - Next cycle: ghist_restore_v_o=1, ghist_restore_o=12'h578, count_o=4.
//     - Tags 4,5 never retire.
//  5. Backpressure: w_ready_i=0 for 5 cycles with head DONE -> w_v_o/idx_w_o stable; retire on the first ready cycle.
//  6. Wrap: run 20 allocate/resolve/retire cycles with depth_p=8.
//     - Tags wrap 7->0; retire order matches allocate order; no spurious resolves.

Source files
------------

// File: rtl/tournament_pkg.sv
// Shared types for the tournament predictor update queue: per-entry
// lifecycle state and the payload captured at prediction/resolve time.
package tournament_pkg;

  // Field widths of the stored entry; the queue's width parameters default
  // to these so the struct and the ports always line up.
  localparam int unsigned tuq_idx_width_c   = 10;
  localparam int unsigned tuq_ghist_width_c = 12;

  // Entry lifecycle: free, waiting for execute, resolved and waiting to retire.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } tuq_state_e;

  // Everything the predictor update and the GHR restore need about one branch.
  typedef struct packed {
    logic [tuq_idx_width_c-1:0]   idx;
    logic [tuq_ghist_width_c-1:0] ghist;
    logic                         pred_taken;
    logic                         choice;
    logic                         taken;
    logic                         correct;
  } tuq_entry_s;

endpackage

// File: rtl/tournament_update_queue_ptr.sv
// Circular-buffer pointer with one extra wrap bit above the index bits.
// Load has priority over increment so a squash can rewind the tail even
// when an allocate is requested in the same cycle.
module tuq_ptr #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  // Pointer register: load wins over increment; wraps modulo 2**width_p.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_o <= '0;
    end else if (load_i) begin
      ptr_o <= load_val_i;
    end else if (inc_i) begin
      ptr_o <= ptr_o + width_p'(1);
    end
  end

endmodule

// File: rtl/tournament_update_queue.sv
// In-flight branch tracker feeding the tournament predictor update port.
// Allocates at fetch, resolves out of order, retires strictly in order,
// and on a mispredict squashes younger entries and emits a GHR restore.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. pred_ready_o depends only on start-of-cycle
// state, never on pred_v_i. Once w_v_o is high it stays high with a stable
// payload until the cycle w_ready_i is also high; w_v_o never depends on
// w_ready_i. res_v_i has no ready: a resolve is taken or silently ignored.
module tournament_update_queue
  import tournament_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = tuq_idx_width_c,
  parameter int unsigned ghist_width_p   = tuq_ghist_width_c,
  parameter int unsigned depth_p         = 8,
  parameter int unsigned tag_width_p     = $clog2(depth_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  output logic                       pred_ready_o,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic [ghist_width_p-1:0]   pred_ghist_i,
  input  logic                       pred_taken_i,
  input  logic                       pred_choice_i,
  output logic [tag_width_p-1:0]     pred_tag_o,
  input  logic                       res_v_i,
  input  logic [tag_width_p-1:0]     res_tag_i,
  input  logic                       res_taken_i,
  output logic                       w_v_o,
  input  logic                       w_ready_i,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic                       taken_o,
  output logic                       choice_o,
  output logic                       ghist_restore_v_o,
  output logic [ghist_width_p-1:0]   ghist_restore_o,
  output logic [tag_width_p:0]       count_o,
  output logic [2*depth_p-1:0]       dbg_state_o
);

  typedef logic [tag_width_p-1:0] tag_t;
  typedef logic [tag_width_p:0]   ptr_t;

  tuq_state_e state_q [depth_p];
  tuq_entry_s entry_q [depth_p];

  ptr_t head_ptr;
  ptr_t tail_ptr;
  tag_t head_idx;
  tag_t tail_idx;

  logic full;
  logic alloc_fire;
  logic res_hit;
  logic res_correct;
  logic mispredict;
  logic retire_fire;
  tag_t res_off;
  ptr_t res_ptr;
  ptr_t tail_load_val;
  logic [depth_p-1:0] younger;
  tuq_entry_s head_entry;

  logic             restore_v_q;
  logic [ghist_width_p-1:0] restore_q;

  assign head_idx = head_ptr[tag_width_p-1:0];
  assign tail_idx = tail_ptr[tag_width_p-1:0];

  // Full: same slot, opposite lap. Empty (head==tail) needs no flag here.
  assign full         = (head_idx == tail_idx) && (head_ptr[tag_width_p] != tail_ptr[tag_width_p]);
  assign pred_ready_o = !full;
  assign pred_tag_o   = tail_idx;
  assign count_o      = tail_ptr - head_ptr;

  assign alloc_fire  = pred_v_i && pred_ready_o;
  assign res_hit     = res_v_i && (state_q[res_tag_i] == PEND);
  assign res_correct = (res_taken_i == entry_q[res_tag_i].pred_taken);
  assign mispredict  = res_hit && !res_correct;

  // Age of the resolved entry relative to head; modular so wrap is harmless.
  assign res_off       = res_tag_i - head_idx;
  assign res_ptr       = head_ptr + ptr_t'(res_off);
  assign tail_load_val = res_ptr + ptr_t'(1);

  // Retire side reads registered state only.
  assign head_entry  = entry_q[head_idx];
  assign w_v_o       = (state_q[head_idx] == DONE);
  assign idx_w_o     = head_entry.idx;
  assign correct_o   = head_entry.correct;
  assign taken_o     = head_entry.taken;
  assign choice_o    = head_entry.choice;
  assign retire_fire = w_v_o && w_ready_i;

  assign ghist_restore_v_o = restore_v_q;
  assign ghist_restore_o   = restore_q;

  // Mark entries allocated after the mispredicted one (head is offset 0, never younger).
  always_comb begin
    younger = '0;
    for (int i = 0; i < depth_p; i++) begin
      younger[i] = (tag_t'(i) - head_idx) > res_off;
    end
  end

  // Pack per-entry states for observation.
  always_comb begin
    dbg_state_o = '0;
    for (int i = 0; i < depth_p; i++) begin
      dbg_state_o[2*i +: 2] = state_q[i];
    end
  end

  tuq_ptr #(.width_p(tag_width_p + 1)) u_head_ptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (retire_fire),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head_ptr)
  );

  // A mispredict rewinds the tail to just past the bad branch and drops any
  // allocate arriving in the same cycle.
  tuq_ptr #(.width_p(tag_width_p + 1)) u_tail_ptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .inc_i      (alloc_fire && !mispredict),
    .load_i     (mispredict),
    .load_val_i (tail_load_val),
    .ptr_o      (tail_ptr)
  );

  // Entry array: allocate at tail, resolve by tag, retire at head, squash younger.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < depth_p; i++) begin
        state_q[i] <= IDLE;
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth_p; i++) begin
        if (alloc_fire && !mispredict && (tail_idx == tag_t'(i))) begin
          state_q[i]            <= PEND;
          entry_q[i].idx        <= pred_idx_i;
          entry_q[i].ghist      <= pred_ghist_i;
          entry_q[i].pred_taken <= pred_taken_i;
          entry_q[i].choice     <= pred_choice_i;
          entry_q[i].taken      <= 1'b0;
          entry_q[i].correct    <= 1'b0;
        end
        if (res_hit && (res_tag_i == tag_t'(i))) begin
          state_q[i]         <= DONE;
          entry_q[i].taken   <= res_taken_i;
          entry_q[i].correct <= res_correct;
        end
        if (retire_fire && (head_idx == tag_t'(i))) begin
          state_q[i] <= IDLE;
        end
        if (mispredict && younger[i]) begin
          state_q[i] <= IDLE;
        end
      end
    end
  end

  // GHR restore: one-cycle pulse after a mispredict; value shifts in the actual outcome.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      restore_v_q <= 1'b0;
      restore_q   <= '0;
    end else begin
      restore_v_q <= mispredict;
      if (mispredict) begin
        restore_q <= {entry_q[res_tag_i].ghist[ghist_width_p-2:0], res_taken_i};
      end
    end
  end

endmodule

// File: tb/tb_tournament_update_queue.sv
// Directed bench for tournament_update_queue: reset, fill, out-of-order
// resolve, mispredict/squash, backpressure and pointer wrap.
module tb_tournament_update_queue;
  import tournament_pkg::*;

  localparam int idx_w = 10;
  localparam int gh_w  = 12;
  localparam int depth = 8;
  localparam int tag_w = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pred_v;
  logic             pred_ready;
  logic [idx_w-1:0] pred_idx;
  logic [gh_w-1:0]  pred_ghist;
  logic             pred_taken;
  logic             pred_choice;
  logic [tag_w-1:0] pred_tag;
  logic             res_v;
  logic [tag_w-1:0] res_tag;
  logic             res_taken;
  logic             w_v;
  logic             w_ready;
  logic [idx_w-1:0] idx_w_val;
  logic             correct;
  logic             taken;
  logic             choice;
  logic             restore_v;
  logic [gh_w-1:0]  restore;
  logic [tag_w:0]   count;
  logic [2*depth-1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [idx_w-1:0] exp_q[$];
  logic [idx_w-1:0] exp_idx;

  // Clock / reset
  always #5 clk = ~clk;

  tournament_update_queue dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .pred_v_i          (pred_v),
    .pred_ready_o      (pred_ready),
    .pred_idx_i        (pred_idx),
    .pred_ghist_i      (pred_ghist),
    .pred_taken_i      (pred_taken),
    .pred_choice_i     (pred_choice),
    .pred_tag_o        (pred_tag),
    .res_v_i           (res_v),
    .res_tag_i         (res_tag),
    .res_taken_i       (res_taken),
    .w_v_o             (w_v),
    .w_ready_i         (w_ready),
    .idx_w_o           (idx_w_val),
    .correct_o         (correct),
    .taken_o           (taken),
    .choice_o          (choice),
    .ghist_restore_v_o (restore_v),
    .ghist_restore_o   (restore),
    .count_o           (count),
    .dbg_state_o       (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pred_v = 1'b0; pred_idx = '0; pred_ghist = '0; pred_taken = 1'b0; pred_choice = 1'b0;
    res_v = 1'b0; res_tag = '0; res_taken = 1'b0; w_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Driver: one allocate request for one cycle.
  task automatic alloc(input logic [idx_w-1:0] idx, input logic [gh_w-1:0] gh,
                       input logic tk, input logic ch);
    pred_v = 1'b1; pred_idx = idx; pred_ghist = gh; pred_taken = tk; pred_choice = ch;
    @(posedge clk); #1;
    pred_v = 1'b0;
  endtask

  // Driver: one resolve for one cycle.
  task automatic resolve(input logic [tag_w-1:0] tg, input logic tk);
    res_v = 1'b1; res_tag = tg; res_taken = tk;
    @(posedge clk); #1;
    res_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_eq("rst_ready", pred_ready, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_wv", w_v, 0);
    check_eq("rst_restore_v", restore_v, 0);
    check_eq("rst_tag", pred_tag, 0);
    check_eq("rst_dbg", dbg_state, 0);

    // 1. Reset mid-operation
    for (int i = 0; i < 3; i++) alloc(idx_w'(i), '0, 1'b1, 1'b0);
    resolve(3'd0, 1'b1);
    check_eq("t1_count3", count, 3);
    check_eq("t1_wv_before", w_v, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t1_count_async", count, 0);
    check_eq("t1_wv_async", w_v, 0);
    check_eq("t1_ready_async", pred_ready, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    // 2. Fill to full
    for (int i = 0; i < depth; i++) begin
      check_eq("t2_tag", pred_tag, i);
      check_eq("t2_ready", pred_ready, 1);
      exp_q.push_back(idx_w'(i));
      alloc(idx_w'(i), gh_w'(i), 1'b1, i[0]);
    end
    check_eq("t2_full_ready", pred_ready, 0);
    check_eq("t2_full_count", count, 8);
    alloc(10'h3FF, '0, 1'b1, 1'b0);
    check_eq("t2_9th_count", count, 8);
    check_eq("t2_9th_ready", pred_ready, 0);

    // 3. Out-of-order resolve 2,1,0
    resolve(3'd2, 1'b1);
    check_eq("t3_wv_after2", w_v, 0);
    resolve(3'd1, 1'b1);
    check_eq("t3_wv_after1", w_v, 0);
    w_ready = 1'b1;
    resolve(3'd0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      exp_idx = exp_q.pop_front();
      check_eq("t3_wv", w_v, 1);
      check_eq("t3_idx", idx_w_val, exp_idx);
      check_eq("t3_correct", correct, 1);
      check_eq("t3_choice", choice, j % 2);
      @(posedge clk); #1;
    end
    check_eq("t3_wv_end", w_v, 0);
    check_eq("t3_count", count, 5);
    check_eq("t3_ready", pred_ready, 1);

    // 4. Mispredict with squash and a discarded same-cycle allocate
    do_reset();
    for (int i = 0; i < 6; i++)
      alloc(idx_w'(10'h100 + i), (i == 3) ? 12'hABC : gh_w'(i), 1'b1, i[0]);
    res_v = 1'b1; res_tag = 3'd3; res_taken = 1'b0;
    pred_v = 1'b1; pred_idx = 10'h3FF;
    @(posedge clk); #1;
    res_v = 1'b0; pred_v = 1'b0;
    check_eq("t4_restore_v", restore_v, 1);
    check_eq("t4_restore", restore, 12'h578);
    check_eq("t4_count", count, 4);
    check_eq("t4_tag", pred_tag, 4);
    @(posedge clk); #1;
    check_eq("t4_restore_pulse", restore_v, 0);
    resolve(3'd2, 1'b1);
    resolve(3'd1, 1'b1);
    resolve(3'd0, 1'b1);
    resolve(3'd4, 1'b0);
    check_eq("t4_squashed4_restore_v", restore_v, 0);
    check_eq("t4_squashed4_count", count, 4);
    resolve(3'd5, 1'b0);
    check_eq("t4_squashed5_restore_v", restore_v, 0);
    w_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq("t4_wv", w_v, 1);
      check_eq("t4_idx", idx_w_val, 10'h100 + j);
      check_eq("t4_correct", correct, (j != 3));
      check_eq("t4_taken", taken, (j != 3));
      @(posedge clk); #1;
    end
    check_eq("t4_wv_end", w_v, 0);
    check_eq("t4_count_end", count, 0);

    // 5. Backpressure
    do_reset();
    alloc(10'h155, 12'h0F0, 1'b0, 1'b1);
    resolve(3'd0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      check_eq("t5_wv_hold", w_v, 1);
      check_eq("t5_idx_hold", idx_w_val, 10'h155);
      @(posedge clk); #1;
    end
    w_ready = 1'b1;
    check_eq("t5_wv_ready", w_v, 1);
    @(posedge clk); #1;
    check_eq("t5_wv_after", w_v, 0);
    check_eq("t5_count_after", count, 0);

    // 6. Wrap-around: allocate/resolve/retire with stale resolves in between
    do_reset();
    w_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_eq("t6_tag", pred_tag, k % depth);
      exp_q.push_back(idx_w'(10'h200 + k));
      alloc(idx_w'(10'h200 + k), gh_w'(k), k[1], k[0]);
      resolve(tag_w'(k % depth), k[0]);
      exp_idx = exp_q.pop_front();
      check_eq("t6_wv", w_v, 1);
      check_eq("t6_idx", idx_w_val, exp_idx);
      check_eq("t6_correct", correct, (k[0] == k[1]));
      check_eq("t6_restore_v", restore_v, (k[0] != k[1]));
      resolve(tag_w'(k % depth), ~k[1]);
      check_eq("t6_stale_wv", w_v, 0);
      check_eq("t6_stale_count", count, 0);
      check_eq("t6_stale_restore_v", restore_v, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
